// File: rtl/handshake_pkg.sv
// handshake_pkg
//   Shared constants and helpers for the handshake constant-sequence source.
//   - DEF_DATA_WIDTH / DEF_COUNT_WIDTH : default parameter values
//   - MAX_DEPTH                        : largest legal table depth
//   - idx_w()                          : index width, clog2 with a 1-bit floor
package handshake_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_COUNT_WIDTH = 16;
  localparam int MAX_DEPTH       = 256;

  // A DEPTH of 1 still needs a 1-bit index register.
  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/handshake_out_reg.sv
// handshake_out_reg
//   One-slot registered output buffer with valid/ready.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     load              write din into the slot this cycle (caller owns the accept)
//     din  [DATA_WIDTH] data to load
//     drain             downstream ready
//     dout [DATA_WIDTH] registered data, holds after drain
//     valid             slot holds an unconsumed token
//     space             slot can take a token this cycle (empty or draining)
module handshake_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  drain,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  space
);

  assign space = !valid | drain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // Load wins over drain: a same-cycle drain+load keeps valid high.
      dout  <= din;
      valid <= 1'b1;
    end else if (valid & drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq
//   Emits the next entry of a compile-time constant table on each accepted
//   control token, cycling 0..DEPTH-1 and wrapping. Output is registered.
//   Optional feature macro: HANDSHAKE_CONSTANT_SEQ_COUNT_EN adds tok_count.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     ctrl_valid/ready  control token handshake (ready forced low in reset)
//     seq_restart       synchronous return of the table index to 0
//     outs, outs_valid  registered constant and its valid
//     outs_ready        downstream accept
//     tok_count         saturating count of delivered tokens (macro only)
module handshake_constant_seq
  import handshake_pkg::*;
#(
  parameter int                          DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                          DEPTH       = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] TABLE       = '0,
  parameter int                          COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_valid,
  output logic                   ctrl_ready,
  input  logic                   seq_restart,
  output logic [DATA_WIDTH-1:0]  outs,
  output logic                   outs_valid,
  input  logic                   outs_ready
`ifdef HANDSHAKE_CONSTANT_SEQ_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] tok_count
`endif
);

  localparam int             IW       = idx_w(DEPTH);
  localparam int             SLOTS    = 1 << IW;
  localparam logic [IW-1:0]  IDX_LAST = IW'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_chk
    $fatal(1, "handshake_constant_seq: DEPTH %0d outside 1..%0d", DEPTH, MAX_DEPTH);
  end
  if (COUNT_WIDTH < 1) begin : g_cnt_chk
    $fatal(1, "handshake_constant_seq: COUNT_WIDTH must be >= 1");
  end

  // Table unpacked into a power-of-two array so every index value is
  // addressable; slots past DEPTH-1 are unreachable and tied to zero.
  logic [DATA_WIDTH-1:0] tbl [SLOTS];
  for (genvar i = 0; i < SLOTS; i++) begin : g_tbl
    if (i < DEPTH) begin : g_ent
      assign tbl[i] = TABLE[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign tbl[i] = '0;
    end
  end

  logic [IW-1:0] idx;
  logic [IW-1:0] idx_eff;
  logic          space;
  logic          acc;

  assign ctrl_ready = rst & space;
  assign acc        = ctrl_valid & ctrl_ready;
  assign idx_eff    = seq_restart ? '0 : idx;

  // Index only moves on accepts or restarts, never on output handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (acc) begin
      idx <= (idx_eff == IDX_LAST) ? '0 : idx_eff + IW'(1);
    end else if (seq_restart) begin
      idx <= '0;
    end
  end

  handshake_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (acc),
    .din   (tbl[idx_eff]),
    .drain (outs_ready),
    .dout  (outs),
    .valid (outs_valid),
    .space (space)
  );

`ifdef HANDSHAKE_CONSTANT_SEQ_COUNT_EN
  // Saturating delivered-token counter; seq_restart does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_count <= '0;
    end else if (outs_valid & outs_ready & (tok_count != '1)) begin
      tok_count <= tok_count + COUNT_WIDTH'(1);
    end
  end
`endif

endmodule
